// File: rtl/zx_keymatrix.sv
// rtl/zx_keymatrix.sv - PS/2 set-2 keyboard to ZX Spectrum 8x5 key matrix with per-key hold counters.
module zx_keymatrix #(
  parameter int ROWS    = 8,
  parameter int COLS    = 5,
  parameter int ROW_LSB = 8,
  parameter int CNT_W   = 2
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        ps2_data_clk,
  input  logic [7:0]  ps2_data,
  input  logic [15:0] A,
  output logic [7:0]  D,
  output logic        key_any,
  output logic        kb_reset
);

  typedef enum logic [2:0] {IDLE, BRK, EXT, EXTBRK, SKIP} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t               state, state_n;
  logic [2:0]           skip_cnt, skip_n;
  logic                 ev_valid, ev_make, ev_accept, clear_all, sel_alt;
  logic [8:0]           ev_code;
  logic [2:0]           p_idx;
  logic [13:0]          keys;
  logic [511:0]         down;
  logic                 alt_down;
  logic [7:0]           punct_alt;
  logic [CNT_W-1:0]     cnt [ROWS][COLS];
  logic                 unused_a;

  assign unused_a = ^A;

  function automatic logic [6:0] kp(input int r, input int c);
    return {1'b1, 3'(r), 3'(c)};
  endfunction

  function automatic logic [2:0] punct_index(input logic [8:0] code);
    logic [2:0] idx;
    idx = 3'd7;
    if (!code[8]) begin
      case (code[7:0])
        8'h41: idx = 3'd0;
        8'h49: idx = 3'd1;
        8'h4A: idx = 3'd2;
        8'h4C: idx = 3'd3;
        8'h52: idx = 3'd4;
        8'h4E: idx = 3'd5;
        8'h55: idx = 3'd6;
        default: idx = 3'd7;
      endcase
    end
    return idx;
  endfunction

  // Returns {second key, first key}; each key is {valid, row[2:0], col[2:0]}.
  function automatic logic [13:0] key_map(input logic [8:0] code, input logic alt);
    logic [6:0] k0, k1;
    k0 = '0;
    k1 = '0;
    if (code[7:0] == 8'h75 || code[7:0] == 8'h6B || code[7:0] == 8'h72 || code[7:0] == 8'h74) begin
      k1 = kp(0, 0);
      case (code[7:0])
        8'h75:   k0 = kp(4, 3);
        8'h6B:   k0 = kp(3, 4);
        8'h72:   k0 = kp(4, 4);
        default: k0 = kp(4, 2);
      endcase
    end else if (!code[8]) begin
      case (code[7:0])
        8'h12: k0 = kp(0, 0);  8'h1A: k0 = kp(0, 1);  8'h22: k0 = kp(0, 2);
        8'h21: k0 = kp(0, 3);  8'h2A: k0 = kp(0, 4);
        8'h1C: k0 = kp(1, 0);  8'h1B: k0 = kp(1, 1);  8'h23: k0 = kp(1, 2);
        8'h2B: k0 = kp(1, 3);  8'h34: k0 = kp(1, 4);
        8'h15: k0 = kp(2, 0);  8'h1D: k0 = kp(2, 1);  8'h24: k0 = kp(2, 2);
        8'h2D: k0 = kp(2, 3);  8'h2C: k0 = kp(2, 4);
        8'h16: k0 = kp(3, 0);  8'h1E: k0 = kp(3, 1);  8'h26: k0 = kp(3, 2);
        8'h25: k0 = kp(3, 3);  8'h2E: k0 = kp(3, 4);
        8'h45: k0 = kp(4, 0);  8'h46: k0 = kp(4, 1);  8'h3E: k0 = kp(4, 2);
        8'h3D: k0 = kp(4, 3);  8'h36: k0 = kp(4, 4);
        8'h4D: k0 = kp(5, 0);  8'h44: k0 = kp(5, 1);  8'h43: k0 = kp(5, 2);
        8'h3C: k0 = kp(5, 3);  8'h35: k0 = kp(5, 4);
        8'h5A: k0 = kp(6, 0);  8'h4B: k0 = kp(6, 1);  8'h42: k0 = kp(6, 2);
        8'h3B: k0 = kp(6, 3);  8'h33: k0 = kp(6, 4);
        8'h29: k0 = kp(7, 0);  8'h59: k0 = kp(7, 1);  8'h3A: k0 = kp(7, 2);
        8'h31: k0 = kp(7, 3);  8'h32: k0 = kp(7, 4);
        8'h58: begin k1 = kp(0, 0); k0 = kp(7, 1); end
        8'h0D: begin k1 = kp(0, 0); k0 = kp(3, 0); end
        8'h66: begin k1 = kp(0, 0); k0 = kp(4, 0); end
        // Punctuation: Symbol Shift plus either the Alt or the plain companion key.
        8'h41: begin k1 = kp(7, 1); k0 = alt ? kp(7, 3) : kp(2, 3); end
        8'h49: begin k1 = kp(7, 1); k0 = alt ? kp(7, 2) : kp(2, 4); end
        8'h4A: begin k1 = kp(7, 1); k0 = alt ? kp(0, 4) : kp(0, 3); end
        8'h4C: begin k1 = kp(7, 1); k0 = alt ? kp(5, 1) : kp(0, 1); end
        8'h52: begin k1 = kp(7, 1); k0 = alt ? kp(4, 3) : kp(5, 0); end
        8'h4E: begin k1 = kp(7, 1); k0 = alt ? kp(6, 3) : kp(4, 0); end
        8'h55: begin k1 = kp(7, 1); k0 = alt ? kp(6, 1) : kp(6, 2); end
        default: begin k0 = '0; k1 = '0; end
      endcase
    end
    return {k1, k0};
  endfunction

  always_comb begin
    state_n   = state;
    skip_n    = skip_cnt;
    ev_valid  = 1'b0;
    ev_make   = 1'b0;
    ev_code   = '0;
    clear_all = 1'b0;
    if (ps2_data_clk) begin
      case (state)
        IDLE: begin
          if (ps2_data == 8'hF0) state_n = BRK;
          else if (ps2_data == 8'hE0) state_n = EXT;
          else if (ps2_data == 8'hE1) begin
            state_n = SKIP;
            skip_n  = 3'd7;
          end else if (ps2_data == 8'hAA || ps2_data == 8'hFC || ps2_data == 8'h00) clear_all = 1'b1;
          else begin
            ev_valid = 1'b1;
            ev_make  = 1'b1;
            ev_code  = {1'b0, ps2_data};
          end
        end
        EXT: begin
          if (ps2_data == 8'hF0) state_n = EXTBRK;
          else begin
            ev_valid = 1'b1;
            ev_make  = 1'b1;
            ev_code  = {1'b1, ps2_data};
            state_n  = IDLE;
          end
        end
        BRK: begin
          ev_valid = 1'b1;
          ev_code  = {1'b0, ps2_data};
          state_n  = IDLE;
        end
        EXTBRK: begin
          ev_valid = 1'b1;
          ev_code  = {1'b1, ps2_data};
          state_n  = IDLE;
        end
        SKIP: begin
          skip_n = skip_cnt - 3'd1;
          if (skip_cnt <= 3'd1) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Breaks reuse the Alt choice latched at make time so the same keys are released.
  always_comb begin
    ev_accept = ev_valid && (ev_make ? !down[ev_code] : down[ev_code]);
    p_idx     = punct_index(ev_code);
    sel_alt   = ev_make ? alt_down : punct_alt[p_idx];
    keys      = key_map(ev_code, sel_alt);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state     <= IDLE;
      skip_cnt  <= '0;
      down      <= '0;
      alt_down  <= 1'b0;
      punct_alt <= '0;
      kb_reset  <= 1'b0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          cnt[r][c] <= '0;
    end else begin
      state    <= state_n;
      skip_cnt <= skip_n;
      kb_reset <= clear_all;
      if (clear_all) begin
        down      <= '0;
        alt_down  <= 1'b0;
        punct_alt <= '0;
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++)
            cnt[r][c] <= '0;
      end else if (ev_accept) begin
        down[ev_code] <= ev_make;
        if (ev_code == 9'h011) alt_down <= ev_make;
        if (ev_make) punct_alt[p_idx] <= alt_down;
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++)
            if ((keys[6] && keys[5:3] == 3'(r) && keys[2:0] == 3'(c)) ||
                (keys[13] && keys[12:10] == 3'(r) && keys[9:7] == 3'(c))) begin
              if (ev_make && cnt[r][c] != CNT_MAX) cnt[r][c] <= cnt[r][c] + CNT_W'(1);
              else if (!ev_make && cnt[r][c] != '0) cnt[r][c] <= cnt[r][c] - CNT_W'(1);
            end
      end
    end
  end

  always_comb begin
    D       = 8'hFF;
    key_any = 1'b0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        if (cnt[r][c] != '0) key_any = 1'b1;
        if (!A[4'(ROW_LSB + r)] && cnt[r][c] != '0) D[c] = 1'b0;
      end
  end

endmodule

// File: doc/zx_keymatrix.md
ZX_KEYMATRIX -- requirements
Module: zx_keymatrix

Interface
REQ-001 SHALL provide parameter ROWS, default 8, meaning number of matrix half-rows.
REQ-002 SHALL provide parameter COLS, default 5, meaning keys per half-row; valid range 1..8.
REQ-003 SHALL provide parameter ROW_LSB, default 8, meaning the A bit that selects row 0; row r is selected by A[ROW_LSB+r].
REQ-004 SHALL provide parameter CNT_W, default 2, meaning the width of the saturating hold counter per matrix key.
REQ-005 SHALL provide port CLOCK_50  in  1  the single system clock; all state changes on its rising edge.
REQ-006 SHALL provide port reset  in  1  synchronous reset, active-high.
REQ-007 SHALL provide port ps2_data_clk  in  1  one-cycle strobe qualifying ps2_data.
REQ-008 SHALL provide port ps2_data  in  8  received PS/2 set-2 byte.
REQ-009 SHALL provide port A  in  16  CPU port address.
REQ-010 SHALL provide port D  out  8  keyboard port read data, active-low.
REQ-011 SHALL provide port key_any  out  1  high while any matrix hold counter is non-zero.
REQ-012 SHALL provide port kb_reset  out  1  one-cycle pulse when the keyboard reports a self-test or error byte.

Function
REQ-013 SHALL compute D combinationally: D[c]=0 iff some row r with A[ROW_LSB+r]=0 has a non-zero counter at (r,c), for c<COLS; D[7:COLS]=1.
REQ-014 SHALL decode bytes with FSM states IDLE, BRK, EXT, EXTBRK and SKIP; bytes are consumed only on cycles with ps2_data_clk=1.
REQ-015 SHALL transition IDLE-F0->BRK, IDLE-E0->EXT, EXT-F0->EXTBRK and IDLE-E1->SKIP with a skip count of 7.
REQ-016 SHALL, from IDLE/EXT, treat any other byte as a make of {ext,code}; from BRK/EXTBRK, as a break; then return to IDLE.
REQ-017 SHALL, in SKIP, decrement the skip count per byte and return to IDLE after the 7th byte, generating no key events.
REQ-018 SHALL keep a 512-entry down table indexed {ext,code}; a make of an already-down code (typematic repeat) and a break of a not-down code are ignored.
REQ-019 SHALL, on an accepted make, set the down bit and increment, saturating at 2^CNT_W-1, the counter of every matrix key mapped to that code; an accepted break clears the bit and decrements the same keys, with a floor of 0.
REQ-020 SHALL map letters, digits, space, enter, left shift (CS, 0,0) and right shift (SS, 7,1) to the standard ZX 8x5 positions.
REQ-021 SHALL map the compound keys to two matrix keys each: CapsLock CS+SS, Tab CS+1, Backspace CS+0, and arrows and keypad 8/4/2/6, with or without E0, to CS+7, CS+5, CS+6 and CS+8.
REQ-022 SHALL map the punctuation keys , . / ; ' - = to SS plus an alternate key while left Alt (11) is down, otherwise to SS plus the primary key.
REQ-023 SHALL latch the Alt selection per punctuation key at make time and use it at break time, so that an Alt change while the key is held never strands a counter.
REQ-024 SHALL update the Alt-down latch on make/break of code 11 (ext=0) and SHALL not drive any matrix key from it.
REQ-025 SHALL ignore unmapped codes apart from the down-table update.
REQ-026 SHALL, on bytes AA, FC or 00 received in IDLE, clear all counters, the down table and the Alt latch, and pulse kb_reset for 1 cycle.
REQ-027 SHALL show a make or break on D and key_any the cycle after the strobe of the final byte.
REQ-028 SHALL, when a strobe arrives in the same cycle as reset, let reset win and discard the byte.

Reset
REQ-029 SHALL set the following on reset: FSM IDLE, skip count 0, all counters 0, down table cleared, Alt latch 0, key_any 0, kb_reset 0.
REQ-030 SHALL read D=FF for every A once reset completes.
REQ-031 SHALL abandon any partial prefix sequence when reset is asserted mid-sequence.

Verification
REQ-032 SHALL cover: make 1C with A=FDFE -> D=FE next cycle; then F0,1C -> D=FF, key_any=0.
REQ-033 SHALL cover: make 12 then make 75 (CS+7), break 75 -> A=FEFE D=FE (CS still held by shift); break 12 -> D=FF.
REQ-034 SHALL cover: make 11, make 41, break 11, then F0,41 -> A=7FFE reads D=F5 while held, then D=FF; no counter stays set.
REQ-035 SHALL cover: five makes of 1C (repeat) then one break -> A=FDFE D=FF.
REQ-036 SHALL cover: E1,14,77,E1,F0,14,F0,77 -> no D change; the next 1C make is decoded normally.
REQ-037 SHALL cover: hold 15 and 16, then AA -> kb_reset pulses 1 cycle and D=FF for A=0000; also reset asserted after E0 -> the next 75 maps as a keypad arrow.
